// File: rtl/vliw_bundle_loader_if.sv
// vliw_bundle_loader_if: host slot-word stream in, packed bundle write port out
interface vliw_bundle_loader_if #(
  parameter int NSLOTS = 8,
  parameter int SLOT_W = 32,
  parameter int ADDR_W = 8
);
  logic in_valid, in_ready, in_end_bundle, in_last;
  logic [SLOT_W-1:0] in_word;
  logic wr_en, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [NSLOTS*SLOT_W-1:0] wr_data;
  modport master (
    input  in_valid, in_word, in_end_bundle, in_last, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data
  );
  modport slave (
    output in_valid, in_word, in_end_bundle, in_last, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/vliw_bundle_loader.sv
// vliw_bundle_loader: packs streamed slot words into NOP-padded VLIW bundles and writes them to instruction memory
module vliw_bundle_loader #(
  parameter int NSLOTS = 8,
  parameter int SLOT_W = 32,
  parameter int ADDR_W = 8,
  parameter int ADDR_STRIDE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [ADDR_W-1:0] base_addr,
  vliw_bundle_loader_if.master bus,
  output logic busy,
  output logic done,
  output logic [ADDR_W-1:0] bundle_count,
  output logic err_overflow
);
  localparam int CW = $clog2(NSLOTS);
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t state, nxt_state;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0] slot_cnt;
  logic last_flag;
  logic [SLOT_W-1:0] slots [NSLOTS];
  logic acc, close, wr_go, stop;
  logic [ADDR_W:0] nxt_addr;
  assign acc = bus.in_valid && bus.in_ready;
  assign close = slot_cnt == CW'(NSLOTS-1) || bus.in_end_bundle || bus.in_last;
  assign wr_go = bus.wr_en && bus.wr_ready;
  assign nxt_addr = {1'b0, addr} + (ADDR_W+1)'(ADDR_STRIDE);
  assign stop = last_flag || nxt_addr[ADDR_W];
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : nxt_state;
  always_comb begin
    nxt_state = state == IDLE  ? (start ? FILL : IDLE) :
                state == FILL  ? (acc && close ? WRITE : FILL) :
                state == WRITE ? (!bus.wr_ready ? WRITE : stop ? DONE : FILL) :
                                 IDLE;
    bus.in_ready = state == FILL;
    bus.wr_en = state == WRITE;
    busy = state != IDLE;
    done = state == DONE;
  end
  assign bus.wr_addr = addr;
  for (genvar i = 0; i < NSLOTS; i++) begin : g_pack
    assign bus.wr_data[(NSLOTS-1-i)*SLOT_W +: SLOT_W] = slots[i];
  end
  // reset and an accepted start share one clear path; only addr differs
  always_ff @(posedge clk)
    if (!rst_n || (state == IDLE && start)) begin
      addr <= rst_n ? base_addr : '0;
      slots <= '{default: '0};
      slot_cnt <= '0;
      last_flag <= 1'b0;
      bundle_count <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (acc) begin
        slots[slot_cnt] <= bus.in_word;
        slot_cnt <= close ? slot_cnt : slot_cnt + CW'(1);
        last_flag <= close ? bus.in_last : last_flag;
      end
      if (wr_go) begin
        slots <= '{default: '0};
        slot_cnt <= '0;
        bundle_count <= bundle_count + ADDR_W'(1);
        err_overflow <= err_overflow || (!last_flag && nxt_addr[ADDR_W]);
        addr <= stop ? addr : nxt_addr[ADDR_W-1:0];
      end
    end
endmodule

// File: tb/tb_vliw_bundle_loader.sv
// tb_vliw_bundle_loader: directed vectors with hand-computed bundles for vliw_bundle_loader
module tb_vliw_bundle_loader;
  localparam int NS = 8;
  localparam int SW = 32;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic busy, done, err_overflow;
  logic [AW-1:0] bundle_count;
  int n_vec = 0;
  int n_bad = 0;
  int n_done = 0;
  logic [AW-1:0] wq_a [$];
  logic [NS*SW-1:0] wq_d [$];

  vliw_bundle_loader_if #(.NSLOTS(NS), .SLOT_W(SW), .ADDR_W(AW)) bus ();

  vliw_bundle_loader #(.NSLOTS(NS), .SLOT_W(SW), .ADDR_W(AW), .ADDR_STRIDE(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .bus(bus),
    .busy(busy), .done(done), .bundle_count(bundle_count), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.wr_en && bus.wr_ready) begin
      wq_a.push_back(bus.wr_addr);
      wq_d.push_back(bus.wr_data);
    end
    if (done) n_done++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] seq(input logic [31:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[(7-i)*32 +: 32] = b + 32'(i);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [AW-1:0] b);
    base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic eb, input logic last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_word = w;
    bus.in_end_bundle = eb;
    bus.in_last = last;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    else tick();
    bus.in_valid = 1'b0;
    bus.in_end_bundle = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic send_seq(input logic [31:0] b, input logic last);
    for (int i = 0; i < 8; i++) send(b + 32'(i), 1'b0, last && i == 7);
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic clrq;
    wq_a.delete();
    wq_d.delete();
  endtask

  initial begin
    int d0;
    logic ok, seen;
    logic [AW-1:0] a;
    logic [255:0] d;
    bus.in_valid = 1'b0;
    bus.in_word = '0;
    bus.in_end_bundle = 1'b0;
    bus.in_last = 1'b0;
    bus.wr_ready = 1'b1;
    tick();
    tick();
    check("reset_outs", {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, busy, done, bundle_count, err_overflow}, 0);
    rst_n = 1'b1;
    tick();

    clrq();
    d0 = n_done;
    go(8'd0);
    send_seq(32'd1, 1'b1);
    check("t1_wr_en", bus.wr_en, 1);
    check("t1_addr", bus.wr_addr, 0);
    check("t1_data", bus.wr_data, seq(32'd1));
    tick();
    check("t1_done", done, 1);
    check("t1_count", bundle_count, 1);
    tick();
    check("t1_done_drop", {done, busy}, 0);
    check("t1_done_cnt", n_done - d0, 1);
    check("t1_writes", wq_a.size(), 1);

    clrq();
    go(8'd0);
    send(32'hA, 1'b0, 1'b0);
    send(32'hB, 1'b0, 1'b0);
    send(32'hC, 1'b1, 1'b0);
    send_seq(32'd11, 1'b1);
    wait_idle();
    check("t2_writes", wq_a.size(), 2);
    check("t2_addr0", wq_a[0], 0);
    check("t2_data0", wq_d[0], {32'hA, 32'hB, 32'hC, 160'd0});
    check("t2_addr1", wq_a[1], 8);
    check("t2_data1", wq_d[1], seq(32'd11));
    check("t2_count", bundle_count, 2);

    clrq();
    bus.wr_ready = 1'b0;
    go(8'd32);
    send_seq(32'd21, 1'b1);
    a = bus.wr_addr;
    d = bus.wr_data;
    ok = bus.wr_en;
    repeat (5) begin
      tick();
      if (!(bus.wr_en && bus.wr_addr == a && bus.wr_data == d && !bus.in_ready && bundle_count == 0)) ok = 1'b0;
    end
    check("t3_stable", ok, 1);
    check("t3_addr", a, 32);
    check("t3_data", d, seq(32'd21));
    bus.wr_ready = 1'b1;
    tick();
    check("t3_done", done, 1);
    check("t3_count", bundle_count, 1);
    check("t3_writes", wq_a.size(), 1);
    tick();

    clrq();
    d0 = n_done;
    go(8'd248);
    send_seq(32'd100, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_word = 32'd108;
    seen = 1'b0;
    repeat (12) begin
      if (bus.in_ready) seen = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    check("t4_no_ready", seen, 0);
    check("t4_err", err_overflow, 1);
    check("t4_writes", wq_a.size(), 1);
    check("t4_addr", wq_a[0], 248);
    check("t4_done_cnt", n_done - d0, 1);
    check("t4_busy", busy, 0);
    go(8'd0);
    check("t4_err_clear", err_overflow, 0);

    clrq();
    d0 = n_done;
    for (int i = 0; i < 4; i++) send(32'd200 + 32'(i), 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check("t5_reset_outs", {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, busy, done, bundle_count, err_overflow}, 0);
    rst_n = 1'b1;
    check("t5_no_write", wq_a.size(), 0);
    check("t5_no_done", n_done - d0, 0);
    go(8'd16);
    send_seq(32'd31, 1'b1);
    wait_idle();
    check("t5_writes", wq_a.size(), 1);
    check("t5_addr", wq_a[0], 16);
    check("t5_data", wq_d[0], seq(32'd31));

    clrq();
    d0 = n_done;
    bus.wr_ready = 1'b0;
    go(8'd64);
    send(32'h77, 1'b0, 1'b1);
    base_addr = 8'd0;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    bus.wr_ready = 1'b1;
    wait_idle();
    repeat (3) tick();
    check("t6_writes", wq_a.size(), 1);
    check("t6_addr", wq_a[0], 64);
    check("t6_data", wq_d[0], {32'h77, 224'd0});
    check("t6_done_cnt", n_done - d0, 1);
    check("t6_count", bundle_count, 1);
    check("t6_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/vliw_bundle_loader.md
Name: vliw_bundle_loader

Overview:
Streams 32-bit slot instructions from a host or loader port into instruction memory as packed VLIW bundles. Successor to the fixed 8-slot, bench-driven instruction write path; slot count, slot width and address stride are parameters. New behaviour over that path:
- early bundle close with NOP padding;
- memory-side backpressure;
- address-overflow detection.

Sits between the program source and the processor's instruction memory write port.

Parameters:
NSLOTS, 8, slots per bundle (>=2)
SLOT_W, 32, bits per slot instruction
ADDR_W, 8, instruction memory address width
ADDR_STRIDE, 8, address increment per written bundle

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin a load session (honoured only in IDLE)
base_addr  input  ADDR_W  first bundle address, latched on accepted start
in_valid  input  1  in_word valid
in_ready  output  1  loader accepts a word this cycle
in_word  input  SLOT_W  slot instruction
in_end_bundle  input  1  with the accepted word: close bundle, pad remaining slots with NOP (all zero)
in_last  input  1  with the accepted word: final word of program; closes bundle and session
wr_en  output  1  bundle write request
wr_ready  input  1  memory accepts write this cycle
wr_addr  output  ADDR_W  bundle address
wr_data  output  NSLOTS*SLOT_W  bundle; slot 0 in the most significant SLOT_W bits
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at end of session
bundle_count  output  ADDR_W  bundles written this session
err_overflow  output  1  sticky; address space exhausted before in_last

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE.
  - All outputs 0: in_ready, wr_en, wr_addr, wr_data, busy, done, bundle_count, err_overflow.
  - Slot buffer cleared, slot counter=0, partial bundle discarded.
  - Reset mid-session aborts with no write and no done.
- States:
  - IDLE:
    - in_ready=0.
    - On start: latch addr=base_addr, clear buffer, slot_cnt=0, bundle_count=0, err_overflow=0; go to FILL.
  - FILL:
    - in_ready=1.
    - On in_valid&in_ready: buffer slot[slot_cnt]=in_word.
    - If slot_cnt==NSLOTS-1, or in_end_bundle, or in_last: latch last_flag=in_last and go to WRITE.
    - Otherwise slot_cnt++.
    - Unwritten slots remain zero (NOP).
  - WRITE:
    - in_ready=0, wr_en=1, wr_addr=addr, wr_data=buffer.
    - All three held stable while wr_ready=0.
    - On wr_ready: bundle_count++, clear buffer, slot_cnt=0, then:
      - last_flag=1: go to DONE.
      - Else if addr+ADDR_STRIDE carries out of ADDR_W bits: set err_overflow, go to DONE.
      - Else: addr+=ADDR_STRIDE, go to FILL.
  - DONE: done=1 for exactly one cycle, then IDLE. err_overflow holds until the next accepted start.
- Latency: the word completing a bundle is accepted at edge N; wr_en is high from cycle N+1.
- Throughput: with wr_ready tied high, one bundle per NSLOTS+1 cycles. Fill and write do not overlap.
- Simultaneous events:
  - in_end_bundle and in_last together: treated as in_last.
  - in_last on the NSLOTS-th word: treated as in_last; no extra empty bundle.
  - start outside IDLE: ignored.
- NOP bundles: the bundle closing word is always stored, so an all-NOP bundle arises only when the host sends zero words.
- Widths: bundle_count wraps modulo 2^ADDR_W. In practice it is bounded by the overflow stop.

Test Plan:
1. NSLOTS=8, base_addr=0, words 1..8 with in_last on 8:
   - One write: wr_addr=0, wr_data={1,2,3,4,5,6,7,8} (slot 0 MSB).
   - done pulse on the cycle after the write handshake; bundle_count=1; busy drops with done.
2. Early close: words A,B,C (in_end_bundle on C), then 8 words ending in_last:
   - Write 1: addr 0, data {A,B,C,0,0,0,0,0}.
   - Write 2: addr 8.
   - bundle_count=2.
3. Backpressure: wr_ready=0 for 5 cycles on a pending write:
   - wr_en, wr_addr and wr_data stable; in_ready=0; bundle_count unchanged.
   - Write completes on the first wr_ready=1 edge.
4. Overflow: base_addr=248, 16 words, no in_last:
   - Single write at 248; err_overflow=1; done pulses; no second write; in_ready=0 afterwards.
   - err_overflow clears on the next start.
5. Reset mid-fill after 4 words (rst_n low one cycle):
   - All outputs 0.
   - New start with base_addr=16 and 8 words: write at 16 containing only the new words (no stale slots).
6. in_last on the first word, plus start pulsed while busy:
   - Write {w,0,0,0,0,0,0,0}.
   - The busy-time start has no effect; exactly one done pulse.
